morse_encoder: RTL and testbench

Plays a stored 10-bit Morse code word back as timed on/off pulses on a single light output. It is the transmit counterpart of the player-input decoder. Codes use the same packing the decoder produces: five 2-bit symbol slots, `2'b01` = dot, `2'b11` = dash, and slot `[1:0]` holds the most recently entered symbol. Player 1's secret word is flashed on an LED through this block, and the hint/replay path in the game top level uses it.

---
 rtl/morse_pkg.sv | 49 ++++
 rtl/morse_unit_timer.sv | 42 ++++
 rtl/morse_encoder.sv | 171 +++++++++++++++++
 tb/tb_morse_encoder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// ============================================================================
// Module      : morse_pkg
// Description : Shared Morse symbol packing, state encoding and slot search.
//               WGAP exists only when MORSE_ENCODER_REPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package morse_pkg;

  localparam int CODE_W = 10;
  localparam int SLOTS  = 5;

  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    ON     = 3'd2,
    OFF    = 3'd3,
    FINISH = 3'd4
`ifdef MORSE_ENCODER_REPEAT_EN
    , WGAP = 3'd5
`endif
  } morse_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } slot_sel_t;

  // Highest slot strictly below 'below' whose bit0 marks a real symbol.
  function automatic slot_sel_t find_slot(input logic [CODE_W-1:0] word,
                                          input logic [2:0]        below);
    slot_sel_t sel;
    sel = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if ((i < int'(below)) && ((word[2*i +: 2] & SYM_DOT) == SYM_DOT)) begin
        sel.found = 1'b1;
        sel.idx   = 3'(i);
      end
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/morse_unit_timer.sv
// ============================================================================
// Module      : morse_unit_timer
// Description : Phase timer; expired flags the last cycle of units*UNIT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_unit_timer #(
  parameter  int UNIT_CYCLES = 25_000_000,
  parameter  int MAX_UNITS   = 7,
  localparam int UW          = $clog2(MAX_UNITS + 1),
  localparam int CW          = $clog2(MAX_UNITS * UNIT_CYCLES + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          clear,
  input  logic [UW-1:0] units,
  output logic          expired
);

  logic [CW-1:0] r_count;
  logic [CW-1:0] r_last;
  logic [CW-1:0] w_last;

  assign w_last  = CW'(units) * CW'(UNIT_CYCLES) - CW'(1);
  assign expired = (r_count == r_last);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_count <= '0;
      r_last  <= '0;
    end else if (clear) begin
      r_count <= '0;
      r_last  <= w_last;
    end else if (!expired) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/morse_encoder.sv
// ============================================================================
// Module      : morse_encoder
// Description : Flashes a packed 5-slot Morse word on led, highest slot first.
//               Define MORSE_ENCODER_REPEAT_EN to replay while start is held.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES    = 25_000_000,
  parameter int DOT_UNITS      = 1,
  parameter int DASH_UNITS     = 3,
  parameter int GAP_UNITS      = 1,
  parameter int WORD_GAP_UNITS = 7
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [CODE_W-1:0] code,
  output logic              led,
  output logic              busy,
  output logic              done
);

  localparam int MAX_A     = (DOT_UNITS > DASH_UNITS) ? DOT_UNITS : DASH_UNITS;
  localparam int MAX_B     = (GAP_UNITS > WORD_GAP_UNITS) ? GAP_UNITS : WORD_GAP_UNITS;
  localparam int MAX_UNITS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int UW        = $clog2(MAX_UNITS + 1);

  morse_state_t      r_state, w_state_nxt;
  logic [CODE_W-1:0] r_word;
  logic [2:0]        r_slot, w_slot_nxt;
  logic              w_slot_load;
  logic              r_armed;
  logic              r_busy, w_busy_nxt;
  logic              w_latch;
  logic              w_tclear;
  logic [UW-1:0]     w_units;
  logic              w_expired;
  slot_sel_t         w_first, w_next;
`ifdef MORSE_ENCODER_REPEAT_EN
  slot_sel_t         w_top;
`endif

  function automatic logic [UW-1:0] on_units(input logic [1:0] sym);
    return (sym == SYM_DASH) ? UW'(DASH_UNITS) : UW'(DOT_UNITS);
  endfunction

  // The slot search is purely combinational, so SCAN never occupies a cycle.
  assign w_first = find_slot(code, 3'(SLOTS));
  assign w_next  = find_slot(r_word, r_slot);
`ifdef MORSE_ENCODER_REPEAT_EN
  assign w_top   = find_slot(r_word, 3'(SLOTS));
`endif

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .MAX_UNITS   (MAX_UNITS)
  ) u_timer (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (w_tclear),
    .units   (w_units),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_slot_load = 1'b0;
    w_slot_nxt  = r_slot;
    w_tclear    = 1'b0;
    w_units     = UW'(GAP_UNITS);
    case (r_state)
      IDLE: begin
        if (start && r_armed) begin
          w_latch = 1'b1;
          if (w_first.found) begin
            w_state_nxt = ON;
            w_slot_load = 1'b1;
            w_slot_nxt  = w_first.idx;
            w_tclear    = 1'b1;
            w_units     = on_units(code[{w_first.idx, 1'b0} +: 2]);
          end else begin
            w_state_nxt = FINISH;
          end
        end
      end
      ON: begin
        if (w_expired) begin
          w_state_nxt = OFF;
          w_tclear    = 1'b1;
          w_units     = UW'(GAP_UNITS);
        end
      end
      OFF: begin
        if (w_expired) begin
          if (w_next.found) begin
            w_state_nxt = ON;
            w_slot_load = 1'b1;
            w_slot_nxt  = w_next.idx;
            w_tclear    = 1'b1;
            w_units     = on_units(r_word[{w_next.idx, 1'b0} +: 2]);
`ifdef MORSE_ENCODER_REPEAT_EN
          end else if (start) begin
            w_state_nxt = WGAP;
            w_tclear    = 1'b1;
            w_units     = UW'(WORD_GAP_UNITS);
`endif
          end else begin
            w_state_nxt = FINISH;
          end
        end
      end
`ifdef MORSE_ENCODER_REPEAT_EN
      WGAP: begin
        if (w_expired) begin
          if (start) begin
            w_state_nxt = ON;
            w_slot_load = 1'b1;
            w_slot_nxt  = w_top.idx;
            w_tclear    = 1'b1;
            w_units     = on_units(r_word[{w_top.idx, 1'b0} +: 2]);
          end else begin
            w_state_nxt = FINISH;
          end
        end
      end
`endif
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // An empty word goes straight from IDLE to FINISH and keeps busy for that cycle.
  assign w_busy_nxt = (w_state_nxt != IDLE) &&
                      !((w_state_nxt == FINISH) && (r_state != IDLE));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_slot  <= '0;
      r_armed <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      if (w_latch) begin
        r_word <= code;
      end
      if (w_slot_load) begin
        r_slot <= w_slot_nxt;
      end
      if (w_latch) begin
        r_armed <= 1'b0;
      end else if ((r_state == IDLE) && !start) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign led  = (r_state == ON);
  assign done = (r_state == FINISH);
  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_morse_encoder.sv
// ============================================================================
// Module      : tb_morse_encoder
// Description : Randomized and directed playback checks against a waveform model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morse_encoder;

  localparam int c_unit  = 4;
  localparam int c_dot   = 1 * c_unit;
  localparam int c_dash  = 3 * c_unit;
  localparam int c_gap   = 1 * c_unit;
  localparam int c_wgap  = 7 * c_unit;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic       start  = 1'b0;
  logic [9:0] code   = '0;
  logic       led;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  morse_encoder #(.UNIT_CYCLES(c_unit)) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .code   (code),
    .led    (led),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected led level per cycle from cycle 1 on; start is high in cycles 0..hold.
  task automatic build_expected(input logic [9:0] c, input int hold);
    bit         one[$];
    logic [1:0] sym;
    one = {};
    exp_q.delete();
    for (int s = 4; s >= 0; s--) begin
      sym = c[2*s +: 2];
      if (sym[0]) begin
        repeat (sym[1] ? c_dash : c_dot) one.push_back(1'b1);
        repeat (c_gap) one.push_back(1'b0);
      end
    end
    foreach (one[i]) exp_q.push_back(one[i]);
`ifdef MORSE_ENCODER_REPEAT_EN
    if (one.size() > 0) begin
      while (exp_q.size() <= hold) begin
        repeat (c_wgap) exp_q.push_back(1'b0);
        if (exp_q.size() > hold) break;
        foreach (one[i]) exp_q.push_back(one[i]);
      end
    end
`endif
  endtask

  task automatic play(input logic [9:0] c, input int hold, input bit chg);
    int         len;
    int         last;
    logic [2:0] e;
    build_expected(c, hold);
    len  = exp_q.size();
    last = ((len > hold) ? len : hold) + 3;
    @(negedge clock);
    code  = c;
    start = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= last; k++) begin
      @(negedge clock);
      if (k <= len)          e = {exp_q[k-1], 1'b1, 1'b0};
      else if (k == len + 1) e = {1'b0, (len == 0), 1'b1};
      else                   e = 3'b000;
      check($sformatf("out code=%03h cyc=%0d {led,busy,done}", c, k),
            32'({led, busy, done}), 32'(e));
      start = (k <= hold);
      if (chg && k == 10) code = c ^ 10'h2A5;
    end
  endtask

  task automatic reset_test();
    @(negedge clock);
    code  = 10'h3FF;
    start = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      check($sformatf("dash cyc=%0d", k), 32'({led, busy, done}), 32'(3'b110));
      start = 1'b0;
    end
    resetn = 1'b0;
    @(negedge clock);
    check("rst_abort", 32'({led, busy, done}), 32'(3'b000));
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("rst_idle", 32'({led, busy, done}), 32'(3'b000));
    end
  endtask

  initial begin
    logic [9:0] rc;
    int         rh;
    bit         rchg;
    repeat (3) @(negedge clock);
    check("reset", 32'({led, busy, done}), 32'(3'b000));
    resetn = 1'b1;

    play(10'b00_0000_0001, 0, 1'b0);
    play(10'b00_0000_0111, 0, 1'b0);
    play(10'b11_11_11_11_11, 0, 1'b1);
    play(10'b00_0000_0000, 0, 1'b0);
    play(10'b00_0010_0001, 0, 1'b0);
    reset_test();
    play(10'b00_0000_0111, 200, 1'b0);
    play(10'b00_0000_0111, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      rc   = 10'($urandom);
      rh   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 120))
                                         : int'($urandom_range(0, 2));
      rchg = 1'($urandom_range(0, 1));
      play(rc, rh, rchg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
